// File: rtl/sel_decoder.sv
// rtl/sel_decoder.sv - per-frame recovery of the AND/OR select key from operand/result samples
module sel_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_s,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_chave,
    output logic       out_ambig,
    output logic       out_err,
    output logic [3:0] out_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic and_ok;
    logic or_ok;
    logic accept;
    logic release_verdict;
    logic and_next;
    logic or_next;

    assign accept          = in_valid & in_ready;
    assign release_verdict = (state_q == REPORT) & out_valid & out_ready;

    // Flags as they stand once the current sample is folded in; the verdict is taken from these.
    assign and_next = and_ok & (in_s == (in_a & in_b));
    assign or_next  = or_ok  & (in_s == (in_a | in_b));

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_last ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_ok    <= 1'b1;
            or_ok     <= 1'b1;
            out_count <= 4'd0;
            out_valid <= 1'b0;
            out_chave <= 1'b0;
            out_ambig <= 1'b0;
            out_err   <= 1'b0;
        end else if (release_verdict) begin
            and_ok    <= 1'b1;
            or_ok     <= 1'b1;
            out_count <= 4'd0;
            out_valid <= 1'b0;
            out_chave <= 1'b0;
            out_ambig <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            and_ok <= and_next;
            or_ok  <= or_next;
            if (out_count != 4'd15) begin
                out_count <= out_count + 4'd1;
            end
            if (in_last) begin
                out_valid <= 1'b1;
                out_chave <= and_next & ~or_next;
                out_ambig <= and_next & or_next;
                out_err   <= ~and_next & ~or_next;
            end
        end
    end

endmodule

// File: tb/tb_sel_decoder.sv
// tb/tb_sel_decoder.sv - self-checking bench for sel_decoder
module tb_sel_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] in_s;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_chave;
    logic       out_ambig;
    logic       out_err;
    logic [3:0] out_count;

    always #5 clk = ~clk;

    sel_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_s      (in_s),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chave (out_chave),
        .out_ambig (out_ambig),
        .out_err   (out_err),
        .out_count (out_count)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       last;
        logic       chave;
        logic       ambig;
        logic       err;
        logic [3:0] count;
    } vec_t;

    typedef struct {
        logic       chave;
        logic       ambig;
        logic       err;
        logic [3:0] count;
    } verdict_t;

    verdict_t sb[$];
    vec_t     vecs[6];
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic c, input logic am, input logic e, input logic [3:0] n);
        verdict_t v;
        v.chave = c;
        v.ambig = am;
        v.err   = e;
        v.count = n;
        sb.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the sample was accepted.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input logic last);
        int n;
        in_a     = a;
        in_b     = b;
        in_s     = s;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 8'd0, 8'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_verdict(input string tag);
        int n;
        verdict_t e;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_chave"}, {7'd0, out_chave}, {7'd0, e.chave});
            chk({tag, "_ambig"}, {7'd0, out_ambig}, {7'd0, e.ambig});
            chk({tag, "_err"},   {7'd0, out_err},   {7'd0, e.err});
            chk({tag, "_count"}, {4'd0, out_count}, {4'd0, e.count});
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_post_out"}, {4'd0, out_chave, out_ambig, out_err, 1'b0} | {4'd0, out_count}, 8'd0);
        chk({tag, "_post_ready"}, {7'd0, in_ready}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        //          a      b      s    last chv amb err cnt
        vecs[0] = '{4'h5, 4'hA, 4'h0, 1'b1, 1, 0, 0, 4'd1};
        vecs[1] = '{4'h5, 4'hA, 4'hF, 1'b0, 0, 0, 0, 4'd0};
        vecs[2] = '{4'h9, 4'h8, 4'h9, 1'b1, 0, 0, 0, 4'd2};
        vecs[3] = '{4'hF, 4'hF, 4'hF, 1'b1, 0, 1, 0, 4'd1};
        vecs[4] = '{4'h5, 4'hA, 4'h6, 1'b1, 0, 0, 1, 4'd1};
        vecs[5] = '{4'h3, 4'h5, 4'h1, 1'b1, 1, 0, 0, 4'd1};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_a = 4'h0; in_b = 4'h0; in_s = 4'h0;
        #12;
        chk("reset_valid", {7'd0, out_valid}, 8'd0);
        chk("reset_outs", {4'd0, out_chave, out_ambig, out_err, 1'b0} | {4'd0, out_count}, 8'd0);
        chk("reset_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].last);
            if (vecs[i].last) begin
                push(vecs[i].chave, vecs[i].ambig, vecs[i].err, vecs[i].count);
                chk($sformatf("vec%0d_latency", i), {7'd0, out_valid}, 8'd1);
                chk($sformatf("vec%0d_ready_low", i), {7'd0, in_ready}, 8'd0);
                check_verdict($sformatf("vec%0d", i));
                handshake($sformatf("vec%0d", i));
            end
        end

        // Consumer stalls 5 cycles while the producer holds the next sample.
        send(4'h5, 4'hA, 4'h0, 1'b1);
        push(1'b1, 1'b0, 1'b0, 4'd1);
        in_a = 4'h3; in_b = 4'h5; in_s = 4'h7; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_ready", {7'd0, in_ready}, 8'd0);
            chk("stall_valid", {7'd0, out_valid}, 8'd1);
            chk("stall_chave", {7'd0, out_chave}, 8'd1);
            chk("stall_count", {4'd0, out_count}, 8'd1);
            @(negedge clk);
        end
        check_verdict("stall");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_release_ready", {7'd0, in_ready}, 8'd1);
        chk("stall_release_valid", {7'd0, out_valid}, 8'd0);
        push(1'b0, 1'b0, 1'b0, 4'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check_verdict("held_sample");
        handshake("held_sample");

        // out_ready already high: handshake in the first REPORT cycle.
        out_ready = 1'b1;
        send(4'hF, 4'h0, 4'h0, 1'b1);
        push(1'b1, 1'b0, 1'b0, 4'd1);
        check_verdict("early_ready");
        @(negedge clk);
        chk("early_ready_done", {7'd0, out_valid}, 8'd0);
        chk("early_ready_in", {7'd0, in_ready}, 8'd1);
        out_ready = 1'b0;

        // 17-sample AND frame: counter saturates at 15.
        for (int k = 0; k < 17; k++) begin
            r = 4'($urandom_range(0, 15));
            send(r, ~r, 4'h0, (k == 16));
        end
        push(1'b1, 1'b0, 1'b0, 4'd15);
        check_verdict("sat");
        handshake("sat");

        // Reset mid-frame.
        for (int k = 0; k < 3; k++) send(4'hC, 4'hA, 4'h8, 1'b0);
        chk("mid_count", {4'd0, out_count}, 8'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_outs", {4'd0, out_chave, out_ambig, out_err, 1'b0} | {4'd0, out_count}, 8'd0);
        chk("mid_rst_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4'h3, 4'h5, 4'h7, 1'b1);
        push(1'b0, 1'b0, 1'b0, 4'd1);
        check_verdict("after_rst");
        handshake("after_rst");

        // Reset during REPORT drops the pending verdict.
        send(4'h3, 4'h5, 4'h1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rep_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rep_rst_chave", {7'd0, out_chave}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4'h6, 4'h6, 4'h6, 1'b1);
        push(1'b0, 1'b1, 1'b0, 4'd1);
        check_verdict("rep_rst_next");
        handshake("rep_rst_next");

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
